// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, ID width, default timeout.
package uart_tx_arbiter_pkg;

   localparam int ID_W             = 3;
   localparam int BUSY_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_RISE = 2'd2,
      ST_WAIT_FALL = 2'd3
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_edge_gen.sv
// Registers the TX engine busy level and derives one-cycle rise/fall pulses.
module edge_gen (
   input  logic clk,
   input  logic rstn,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_sig_q;

   // Previous-cycle copy of the level; cleared on reset so a high level after release reads as a rise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_sig_q <= 1'b0;
      else       r_sig_q <= i_sig;
   end

   assign o_rise = i_sig & ~r_sig_q;
   assign o_fall = ~i_sig & r_sig_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting N_REQ byte requesters access to one UART TX byte engine.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | no transfer; pick next requester when any req is high
//  ISSUE      | one cycle: tx_start and ack[cur_id] pulse
//  WAIT_RISE  | wait for tx_busy to rise; time out after BUSY_TIMEOUT cycles
//  WAIT_FALL  | engine busy; pulse done when tx_busy falls
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic               done,
   output logic               timeout_err,
   output logic [ID_W-1:0]    cur_id,
   output logic               active
);

   localparam logic [1:0] S_IDLE      = ST_IDLE;
   localparam logic [1:0] S_ISSUE     = ST_ISSUE;
   localparam logic [1:0] S_WAIT_RISE = ST_WAIT_RISE;
   localparam logic [1:0] S_WAIT_FALL = ST_WAIT_FALL;

   localparam int              CNT_W    = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [ID_W-1:0]  r_cur_id;
   logic [ID_W-1:0]  r_last_grant;
   logic [7:0]       r_tx_data;

   logic             w_rise;
   logic             w_fall;
   logic             w_any_req;
   logic             w_issue;
   logic             w_expire;
   logic [ID_W-1:0]  w_pick;
   logic [7:0]       w_pick_data;
   logic [N_REQ-1:0] w_ack;

   // Lowest offset from last+1 wins; scanning offsets high-to-low lets the nearest overwrite.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  last);
      logic [ID_W-1:0] pick;
      pick = last;
      for (int k = N_REQ; k >= 1; k--) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (r[j] && (j == ((int'(last) + k) % N_REQ))) pick = ID_W'(j);
         end
      end
      return pick;
   endfunction

   edge_gen u_busy_edge (
      .clk    (clk),
      .rstn   (rstn),
      .i_sig  (tx_busy),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_any_req = |req;
   assign w_pick    = rr_pick(req, r_last_grant);
   assign w_issue   = (r_state == S_ISSUE);
   assign w_expire  = (r_cnt == CNT_LAST);

   // Byte of the requester that would win this cycle.
   always_comb begin
      w_pick_data = 8'h00;
      for (int j = 0; j < N_REQ; j++) begin
         if (w_pick == ID_W'(j)) w_pick_data = req_data[8*j +: 8];
      end
   end

   // One-hot acknowledge of the latched requester during ISSUE.
   always_comb begin
      w_ack = '0;
      for (int j = 0; j < N_REQ; j++) begin
         w_ack[j] = w_issue && (r_cur_id == ID_W'(j));
      end
   end

   // Transfer sequencing; grant bookkeeping only moves on IDLE-to-ISSUE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_cur_id     <= '0;
         r_last_grant <= ID_W'(N_REQ - 1);
         r_tx_data    <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_cur_id     <= w_pick;
                  r_last_grant <= w_pick;
                  r_tx_data    <= w_pick_data;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
               if (w_rise)        r_state <= S_WAIT_FALL;
               else if (w_expire) r_state <= S_IDLE;
               else               r_cnt   <= r_cnt + 1'b1;
            end
            S_WAIT_FALL: begin
               if (w_fall) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ack         = w_ack;
   assign tx_start    = w_issue;
   assign tx_data     = r_tx_data;
   assign cur_id      = r_cur_id;
   assign active      = (r_state != S_IDLE);
   assign done        = (r_state == S_WAIT_FALL) && w_fall;
   assign timeout_err = (r_state == S_WAIT_RISE) && !w_rise && w_expire;

endmodule
